// File: rtl/lc3_mem_pkg.sv
// LC-3 memory controller shared definitions.
// Device register addresses, MMIO window base and controller state type.
package lc3_mem_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } mem_state_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 device registers: KBSR/KBDR, DSR/DDR, MCR plus kbd/display handshakes.
// Ports: acc/we/addr/wdata strobe from parent, rdata read mux, kbd_*, dsp_*, halted.
module lc3_mmio_regs
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data,
  input  logic              dsp_ready,
  output logic              halted
);

  logic       kbd_rdy;
  logic       kbd_ie;
  logic [7:0] kbd_char;
  logic       dsp_rdy;

  logic hit_kbsr;
  logic hit_kbdr;
  logic hit_dsr;
  logic hit_ddr;
  logic hit_mcr;

  assign hit_kbsr = addr == ADDR_W'(KBSR_ADDR);
  assign hit_kbdr = addr == ADDR_W'(KBDR_ADDR);
  assign hit_dsr  = addr == ADDR_W'(DSR_ADDR);
  assign hit_ddr  = addr == ADDR_W'(DDR_ADDR);
  assign hit_mcr  = addr == ADDR_W'(MCR_ADDR);

  logic wr_kbsr;
  logic rd_kbdr;
  logic wr_ddr;
  logic wr_halt;

  assign wr_kbsr = acc && we && hit_kbsr;
  assign rd_kbdr = acc && !we && hit_kbdr;
  assign wr_ddr  = acc && we && hit_ddr;
  assign wr_halt = acc && we && hit_mcr && !wdata[15];

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_kbsr: rdata = DATA_W'({kbd_rdy, kbd_ie, 14'b0});
      hit_kbdr: rdata = DATA_W'({8'h00, kbd_char});
      hit_dsr:  rdata = DATA_W'({dsp_rdy, 15'b0});
      hit_ddr:  rdata = DATA_W'({8'h00, dsp_data});
      hit_mcr:  rdata = DATA_W'({~halted, 15'b0});
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbd_rdy   <= 1'b0;
      kbd_ie    <= 1'b0;
      kbd_char  <= 8'h00;
      dsp_rdy   <= 1'b1;
      dsp_valid <= 1'b0;
      dsp_data  <= 8'h00;
      halted    <= 1'b0;
    end else begin
      // A KBDR read frees the slot on this edge, so a
      // same-cycle strobe lands instead of being dropped.
      if (kbd_valid && (!kbd_rdy || rd_kbdr)) begin
        kbd_char <= kbd_data;
        kbd_rdy  <= 1'b1;
      end else if (rd_kbdr) begin
        kbd_rdy <= 1'b0;
      end
      if (wr_kbsr) begin
        kbd_ie <= wdata[14];
      end
      if (wr_ddr) begin
        dsp_data  <= wdata[7:0];
        dsp_valid <= 1'b1;
        dsp_rdy   <= 1'b0;
      end else if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
        dsp_rdy   <= 1'b1;
      end
      if (wr_halt) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: req/ready + resp pulse, wait states, array, MMIO.
// Ports: clk, rst_n, req_*, resp_*, kbd_*, dsp_*, halted.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data,
  input  logic              dsp_ready,
  output logic              halted
);

  localparam int CNT_W =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mmio_q;
  logic              in_acc;
  logic              mem_we;
  logic [DATA_W-1:0] mmio_rdata;

  assign mmio_q = addr_q >= ADDR_W'(MMIO_BASE);
  assign in_acc = state == ACCESS;
  // rst_n gate: a reset landing on the ACCESS edge
  // must not commit the in-flight write.
  assign mem_we = in_acc && we_q && !mmio_q && rst_n;

  assign req_ready = rst_n && (state == IDLE)
                  && req_valid && !halted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= '0;
            state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          if (!we_q) begin
            resp_rdata <= mmio_q ? mmio_rdata : mem[addr_q];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  lc3_mmio_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mmio (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc       (in_acc && mmio_q),
    .we        (we_q),
    .addr      (addr_q),
    .wdata     (wdata_q),
    .rdata     (mmio_rdata),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data),
    .dsp_ready (dsp_ready),
    .halted    (halted)
  );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: two instances (2 and 0 wait states).
// Driver pushes expected rdata/latency; negedge monitor pops on resp_valid.
module tb_lc3_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rv [2];
  logic        rr [2];
  logic        resp_v [2];
  logic [15:0] rdata [2];
  logic        dsp_v [2];
  logic [7:0]  dsp_d [2];
  logic        halted [2];
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        dsp_ready;

  lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_ready(rr[0]),
    .resp_valid(resp_v[0]), .resp_rdata(rdata[0]),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .dsp_valid(dsp_v[0]), .dsp_data(dsp_d[0]),
    .dsp_ready(dsp_ready), .halted(halted[0])
  );

  lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_ready(rr[1]),
    .resp_valid(resp_v[1]), .resp_rdata(rdata[1]),
    .kbd_valid(1'b0), .kbd_data(8'h00),
    .dsp_valid(dsp_v[1]), .dsp_data(dsp_d[1]),
    .dsp_ready(1'b1), .halted(halted[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int wt [2] = '{2, 0};
  int busy_end [2];

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // reference model
  logic [15:0] mem_m [int];
  logic [15:0] last_rd [2];
  bit          k_rdy, k_ie, d_rdy, d_valid, m_halt;
  logic [7:0]  k_char, d_data;

  task automatic model_reset();
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    k_rdy = 0; k_ie = 0; k_char = 8'h00;
    d_rdy = 1; d_valid = 0; d_data = 8'h00;
    m_halt = 0;
    busy_end[0] = 0; busy_end[1] = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_access(input int d, input bit w,
                              input logic [15:0] a,
                              input logic [15:0] wd,
                              output logic [15:0] r);
    int key;
    key = d * 65536 + int'(a);
    if (a < 16'hFE00) begin
      if (w) mem_m[key] = wd;
      else last_rd[d] = mem_m.exists(key) ? mem_m[key] : 16'h0;
    end else if (w) begin
      if (a == 16'hFE00) k_ie = wd[14];
      if (a == 16'hFE06) begin
        d_data = wd[7:0]; d_valid = 1; d_rdy = 0;
      end
      if (a == 16'hFFFE && !wd[15]) m_halt = 1;
    end else begin
      case (a)
        16'hFE00: last_rd[d] = {k_rdy, k_ie, 14'b0};
        16'hFE02: begin
          last_rd[d] = {8'h00, k_char};
          k_rdy = 0;
        end
        16'hFE04: last_rd[d] = {d_rdy, 15'b0};
        16'hFE06: last_rd[d] = {8'h00, d_data};
        16'hFFFE: last_rd[d] = {~m_halt, 15'b0};
        default:  last_rd[d] = 16'h0;
      endcase
    end
    r = last_rd[d];
  endtask

  task automatic kbd_strobe_model(input logic [7:0] ch);
    if (!k_rdy) begin
      k_char = ch;
      k_rdy = 1;
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic issue(input int d, input bit w,
                       input logic [15:0] a, input logic [15:0] wd,
                       input bit kbd_acc, input logic [7:0] kch);
    int n;
    int acc;
    exp_t e;
    @(negedge clk);
    we = w; addr = a; wdata = wd; rv[d] = 1'b1;
    #1;
    n = 0;
    while (!rr[d]) begin
      if (n == 40) begin
        chk("accept_timeout", 32'(rr[d]), 32'd1);
        rv[d] = 1'b0;
        return;
      end
      @(negedge clk); #1;
      n++;
    end
    acc = cyc;
    chk("ready_while_busy", 32'(acc >= busy_end[d]), 32'd1);
    busy_end[d] = acc + wt[d] + 2;
    model_access(d, w, a, wd, e.d);
    e.c = acc + wt[d] + 2;
    push_exp(d, e);
    @(posedge clk); #1;
    rv[d] = 1'b0;
    if (kbd_acc) begin
      while (cyc < acc + wt[d] + 1) @(negedge clk);
      kbd_valid = 1'b1; kbd_data = kch;
      @(negedge clk);
      kbd_valid = 1'b0;
      kbd_strobe_model(kch);
    end
  endtask

  task automatic rd(input int d, input logic [15:0] a);
    issue(d, 1'b0, a, 16'h0, 1'b0, 8'h00);
  endtask

  task automatic wr(input int d, input logic [15:0] a,
                    input logic [15:0] v);
    issue(d, 1'b1, a, v, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 32'(qsize(d)), 32'd0);
  endtask

  task automatic kbd_pulse(input logic [7:0] ch);
    wait_idle(0);
    kbd_valid = 1'b1; kbd_data = ch;
    @(negedge clk);
    kbd_valid = 1'b0;
    kbd_strobe_model(ch);
  endtask

  task automatic pop_check(input int d);
    exp_t e;
    if (qsize(d) == 0) begin
      chk("unexpected_resp", 32'(resp_v[d]), 32'd0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk("rdata", 32'(rdata[d]), 32'(e.d));
    chk("latency", 32'(cyc), 32'(e.c));
  endtask

  always @(negedge clk) begin
    if (resp_v[0] === 1'b1) pop_check(0);
    if (resp_v[1] === 1'b1) pop_check(1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rv[0] = 1'b0; rv[1] = 1'b0;
    we = 1'b0; addr = 16'h0; wdata = 16'h0;
    kbd_valid = 1'b0; kbd_data = 8'h00;
    dsp_ready = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    rv[0] = 1'b1;
    #1;
    chk("rst_req_ready", 32'(rr[0]), 32'd0);
    chk("rst_resp_valid", 32'(resp_v[0]), 32'd0);
    chk("rst_resp_rdata", 32'(rdata[0]), 32'd0);
    chk("rst_dsp_valid", 32'(dsp_v[0]), 32'd0);
    chk("rst_dsp_data", 32'(dsp_d[0]), 32'd0);
    chk("rst_halted", 32'(halted[0]), 32'd0);
    rv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // instruction fetch back-to-back
    for (int i = 0; i < 4; i++) wr(0, 16'(i), 16'h1021 + 16'(i));
    for (int i = 0; i < 4; i++) rd(0, 16'(i));

    // write/read-back, both wait-state settings
    wr(0, 16'h3000, 16'hBEEF);
    rd(0, 16'h3000);
    wr(1, 16'h3000, 16'hBEEF);
    rd(1, 16'h3000);
    wr(1, 16'h3000, 16'h1111);
    rd(1, 16'h3000);

    // keyboard
    kbd_pulse(8'h41);
    rd(0, 16'hFE00);
    kbd_pulse(8'h42);
    rd(0, 16'hFE02);
    rd(0, 16'hFE00);
    issue(0, 1'b0, 16'hFE02, 16'h0, 1'b1, 8'h43);
    rd(0, 16'hFE00);
    rd(0, 16'hFE02);
    wr(0, 16'hFE00, 16'h4000);
    rd(0, 16'hFE00);

    // display
    wr(0, 16'hFE06, 16'h0048);
    wait_idle(0);
    chk("dsp_valid_set", 32'(dsp_v[0]), 32'(d_valid));
    chk("dsp_data", 32'(dsp_d[0]), 32'(d_data));
    rd(0, 16'hFE04);
    wait_idle(0);
    repeat (5) @(negedge clk);
    chk("dsp_valid_hold", 32'(dsp_v[0]), 32'(d_valid));
    dsp_ready = 1'b1;
    @(negedge clk);
    dsp_ready = 1'b0;
    d_valid = 0; d_rdy = 1;
    chk("dsp_valid_clr", 32'(dsp_v[0]), 32'(d_valid));
    rd(0, 16'hFE04);
    rd(0, 16'hFE06);

    // randomized array/unmapped traffic
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        wr(d, 16'h0100 + 16'(i), 16'($urandom));
      for (int i = 0; i < 60; i++) begin
        int op;
        logic [15:0] a;
        op = $urandom_range(0, 9);
        a = 16'h0100 + 16'($urandom_range(0, 15));
        if (op < 4) wr(d, a, 16'($urandom));
        else if (op < 8) rd(d, a);
        else if (op == 8) rd(d, 16'hFE08 + 16'($urandom_range(0, 500)));
        else wr(d, 16'hFE08 + 16'($urandom_range(0, 500)),
                16'($urandom));
      end
      wait_idle(d);
    end

    // reset in the middle of a write
    wr(0, 16'h4000, 16'h1234);
    wait_idle(0);
    wr(0, 16'h4000, 16'hDEAD);
    mem_m[16'h4000] = 16'h1234;
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    repeat (2) @(negedge clk);
    chk("mid_rst_resp_valid", 32'(resp_v[0]), 32'd0);
    chk("mid_rst_rdata", 32'(rdata[0]), 32'd0);
    chk("mid_rst_dsp_valid", 32'(dsp_v[0]), 32'd0);
    chk("mid_rst_halted", 32'(halted[0]), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd(0, 16'h4000);
    rd(0, 16'hFE04);
    wait_idle(0);

    // halt
    wr(0, 16'hFFFE, 16'h8000);
    rd(0, 16'hFFFE);
    wr(0, 16'hFFFE, 16'h0000);
    wait_idle(0);
    chk("halted", 32'(halted[0]), 32'(m_halt));
    @(negedge clk);
    we = 1'b0; addr = 16'h0; rv[0] = 1'b1;
    n = 0;
    repeat (20) begin
      #1;
      if (rr[0]) n++;
      @(negedge clk);
    end
    rv[0] = 1'b0;
    chk("halt_refuse", 32'(n), 32'd0);
    rd(1, 16'h3000);
    wait_idle(1);
    chk("q0_empty", 32'(q0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
LC-3 memory controller with the MAR/MDR-style request/ready handshake.
- Sits directly upstream of the control FSM's instruction-register load. The fetch step issues a read at PC and loads IR from resp_rdata. Data loads and stores use the same port.
- Owns the main memory array, a programmable wait-state counter and the LC-3 memory-mapped device registers: KBSR, KBDR, DSR, DDR and MCR.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, word width.
- WAIT_CYCLES, 2, extra cycles between request accept and response; 0 is legal.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  access request from the control FSM.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address (MAR).
- req_wdata  in  DATA_W  write data (MDR).
- req_ready  out  1  request accepted this cycle.
- resp_valid  out  1  LC-3 "R": access complete, one-cycle pulse.
- resp_rdata  out  DATA_W  read data; held until the next response.
- kbd_valid  in  1  keyboard character strobe.
- kbd_data  in  8  keyboard character.
- dsp_valid  out  1  display character pending.
- dsp_data  out  8  display character.
- dsp_ready  in  1  display consumes the character when dsp_valid && dsp_ready.
- halted  out  1  MCR[15] cleared by software.

Behaviour:
Reset (rst_n=0 at a clk edge):
- State returns to IDLE.
- req_ready=0, resp_valid=0, resp_rdata=0, dsp_valid=0, dsp_data=0, halted=0.
- KBSR=0, DSR[15]=1, MCR[15]=1.
- Memory array contents are not cleared.
- A reset mid-operation drops the in-flight request. No response is issued and no write is committed.

State machine:
- IDLE:
  - req_ready = req_valid && !halted (combinational).
  - On accept, latch we/addr/wdata and clear the wait counter.
  - If WAIT_CYCLES=0, go to ACCESS; otherwise go to WAIT.
- WAIT: counter increments each cycle; at WAIT_CYCLES-1, go to ACCESS.
- ACCESS:
  - Perform the memory or register access.
  - Register resp_rdata (reads only; writes leave it unchanged).
  - Pulse resp_valid the next cycle and return to IDLE.
- Latency: request accepted at cycle N gives resp_valid at cycle N+WAIT_CYCLES+2.
- req_valid outside IDLE is not accepted. The requester holds its request until req_ready.

Address decode (addresses 0xFE00 and above; all other addresses go to the array):
- xFE00 KBSR:
  - Read returns {kbd_rdy, kbd_ie, 14'b0}.
  - Write updates kbd_ie from bit14 only.
- xFE02 KBDR:
  - Read returns {8'h00, kbd_char} and clears kbd_rdy.
  - Writes are ignored.
- xFE04 DSR:
  - Read returns {dsp_rdy, 15'b0}.
  - Writes are ignored.
- xFE06 DDR:
  - Write latches wdata[7:0] into dsp_data, sets dsp_valid and clears dsp_rdy.
  - Read returns {8'h00, dsp_data}.
- xFFFE MCR:
  - Read returns {run, 15'b0}.
  - A write with bit15=0 clears run and asserts halted (sticky until reset).
  - Writing bit15=1 has no effect.
- Other xFE00–xFFFF addresses read 0 and ignore writes.

Keyboard:
- kbd_valid with kbd_rdy=0 latches kbd_char and sets kbd_rdy.
- kbd_valid with kbd_rdy=1 drops the character (no overwrite).
- Simultaneous kbd_valid and a KBDR read in ACCESS: the read returns the old character, the new character is latched, and kbd_rdy stays 1.

Display:
- dsp_valid && dsp_ready clears dsp_valid and sets dsp_rdy on the same edge.
- A DDR write while dsp_valid=1 overwrites dsp_data and keeps dsp_valid=1. Software must poll DSR first.

Halt: once halted=1, new requests are refused. A request already in flight completes.

Decomposition:
- Package lc3_mem_pkg:
  - Address constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR and MMIO_BASE (xFE00).
  - mem_state_t enum {IDLE, WAIT, ACCESS}.
- Sub-module lc3_mmio_regs: KBSR/KBDR/DSR/DDR/MCR registers and keyboard/display handshakes, with a read mux and write strobe from the parent.
- The parent keeps the FSM, wait counter and array.

Test Plan:
- Instruction fetch: preload mem[0..3]=x1021,x1022,x1023,x1024, WAIT_CYCLES=2, read addr 0..3 back-to-back -> each resp_valid 4 cycles after accept, rdata x1021..x1024 in order, req_ready low while busy.
- Write/read-back: write x3000←xBEEF then read x3000 -> rdata xBEEF. The write response leaves the prior rdata unchanged. Repeat with WAIT_CYCLES=0 -> resp 2 cycles after accept.
- Keyboard: kbd_valid with x41 -> KBSR reads x8000. Send kbd_valid x42 (dropped). KBDR read -> x0041, then KBSR reads x0000. Same-cycle kbd x43 during KBDR read -> x0041 returned, KBSR stays x8000.
- Display: write DDR x0048 -> dsp_valid=1, dsp_data=x48, DSR reads x0000. Hold dsp_ready low 5 cycles, then pulse -> dsp_valid=0, DSR reads x8000.
- Halt: write MCR x0000 -> halted=1 after that response. A following read at x0000 is never accepted (req_ready stays 0).
- Reset mid-access: assert rst_n=0 during WAIT of a write to x4000 -> no resp_valid, mem[x4000] unchanged, outputs at reset values, DSR reads x8000 afterwards.
